// File: rtl/bad_hash_client_pkg.sv
// Shared types for the hash-engine client: FSM states, default key and result entry.
package bad_hash_client_pkg;

  localparam logic [31:0] DEFAULT_KEY = 32'h1ea14969;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } result_t;

endpackage

// File: rtl/bad_hash_client_fifo.sv
// Two-entry result buffer; head visible combinationally, push and pop may coincide.
module bad_hash_client_fifo
  import bad_hash_client_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  result_t push_data,
  input  logic    pop,
  output logic    full,
  output logic    empty,
  output result_t head
);

  result_t    mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       do_push;
  logic       do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_pop  = pop && !empty;
  // When full, a simultaneous pop frees the slot the push is about to write.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/bad_hash_client.sv
// Issues one word at a time to an XOR hash engine, times out stalled requests, buffers results.
// Optional response check and err_count enabled by BAD_HASH_CLIENT_CHECK_EN.
module bad_hash_client
  import bad_hash_client_pkg::*;
#(
  parameter logic [31:0] KEY     = DEFAULT_KEY,
  parameter int          TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic [31:0] cmd_data,
  output logic        cmd_ready,
  output logic [31:0] eng_in_data,
  output logic        eng_in_ready,
  input  logic [31:0] eng_out_data,
  input  logic [31:0] eng_out_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
`ifdef BAD_HASH_CLIENT_CHECK_EN
  output logic [7:0]  err_count,
`endif
  input  logic        rsp_ready
);

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic [31:0] word_q, word_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        push;
  result_t     push_res;
  result_t     head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        check_fail;
  logic        unused_bits;

  assign unused_bits = ^{eng_out_ready[31:1], KEY};

`ifdef BAD_HASH_CLIENT_CHECK_EN
  assign check_fail = ((eng_out_data ^ KEY) != word_q);
`else
  assign check_fail = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      word_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    cnt_d        = cnt_q;
    cmd_ready    = 1'b0;
    eng_in_ready = 1'b0;
    push         = 1'b0;
    push_res     = '0;
    case (state_q)
      IDLE: begin
        cmd_ready = !fifo_full;
        if (cmd_valid && !fifo_full) begin
          word_d  = cmd_data;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        eng_in_ready = 1'b1;
        cnt_d        = '0;
        state_d      = WAIT;
      end
      WAIT: begin
        // A response arriving on the timeout cycle takes priority.
        if (eng_out_ready[0]) begin
          push          = 1'b1;
          push_res.err  = check_fail;
          push_res.data = eng_out_data;
          state_d       = IDLE;
        end else if (cnt_q + 8'd1 == TMO) begin
          push          = 1'b1;
          push_res.err  = 1'b1;
          push_res.data = '0;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign eng_in_data = word_q;

  bad_hash_client_fifo u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_res),
    .pop       (rsp_valid && rsp_ready),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head)
  );

  assign rsp_valid = !fifo_empty;
  assign rsp_data  = head.data;
  assign rsp_err   = head.err;

`ifdef BAD_HASH_CLIENT_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      err_count <= '0;
    end else if (push && push_res.err && err_count != 8'hff) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bad_hash_client.sv
// Directed bench for bad_hash_client with a behavioural XOR engine of programmable delay.
module tb_bad_hash_client;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic [31:0] cmd_data;
  logic        cmd_ready;
  logic [31:0] eng_in_data;
  logic        eng_in_ready;
  logic [31:0] eng_out_data;
  logic [31:0] eng_out_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        rsp_ready;
`ifdef BAD_HASH_CLIENT_CHECK_EN
  logic [7:0]  err_count;
`endif

  int n_vec = 0;
  int n_err = 0;
  int n;

  // engine model controls
  logic        eng_en, eng_bad, force_rdy;
  logic [30:0] eng_hi;
  int          eng_delay;
  logic        pend;
  int          dcnt;
  logic [31:0] eng_res;

  always #5 clk = ~clk;

  bad_hash_client dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_data      (cmd_data),
    .cmd_ready     (cmd_ready),
    .eng_in_data   (eng_in_data),
    .eng_in_ready  (eng_in_ready),
    .eng_out_data  (eng_out_data),
    .eng_out_ready (eng_out_ready),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .rsp_err       (rsp_err),
`ifdef BAD_HASH_CLIENT_CHECK_EN
    .err_count     (err_count),
`endif
    .rsp_ready     (rsp_ready)
  );

  always @(posedge clk) begin
    if (reset) begin
      pend    <= 1'b0;
      dcnt    <= 0;
      eng_res <= '0;
    end else if (eng_in_ready && eng_en) begin
      pend    <= 1'b1;
      dcnt    <= eng_delay;
      eng_res <= eng_bad ? 32'hDEADBEEF : (eng_in_data ^ 32'h1ea14969);
    end else if (pend) begin
      if (dcnt == 0) pend <= 1'b0;
      else           dcnt <= dcnt - 1;
    end
  end

  assign eng_out_ready = {eng_hi, (pend && dcnt == 0) || force_rdy};
  assign eng_out_data  = eng_res;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Cycles until rsp_valid, or -1 when the budget runs out.
  task automatic wait_rsp(input int max, output int cycles);
    cycles = 0;
    while (!rsp_valid && cycles < max) begin
      tick();
      cycles++;
    end
    if (!rsp_valid) cycles = -1;
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_data = '0; rsp_ready = 1'b1;
    eng_en = 1'b1; eng_bad = 1'b0; force_rdy = 1'b0; eng_hi = '0; eng_delay = 0;
    repeat (2) tick();
    reset = 1'b0;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_eng_in_ready", eng_in_ready, 0);
    check("rst_eng_in_data", eng_in_data, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_err", rsp_err, 0);

    // zero word through a KEY engine, 3-cycle latency
    cmd_valid = 1'b1; cmd_data = 32'h0;
    tick();
    cmd_valid = 1'b0;
    check("zero_strobe", eng_in_ready, 1);
    check("zero_in_data", eng_in_data, 32'h0);
    tick();
    check("zero_strobe_len", eng_in_ready, 0);
    check("zero_no_rsp_yet", rsp_valid, 0);
    tick();
    check("zero_rsp_valid", rsp_valid, 1);
    check("zero_rsp_data", rsp_data, 32'h1ea14969);
    check("zero_rsp_err", rsp_err, 0);
    tick();
    check("zero_popped", rsp_valid, 0);

    // engine silent, upper ready bits set: timeout 16 cycles after ISSUE
    eng_en = 1'b0; eng_hi = '1;
    cmd_valid = 1'b1; cmd_data = 32'h0BADF00D;
    tick();
    cmd_valid = 1'b0;
    check("tmo_strobe", eng_in_ready, 1);
    wait_rsp(40, n);
    check("tmo_latency", n, 16);
    check("tmo_err", rsp_err, 1);
    check("tmo_data", rsp_data, 32'h0);
    tick();
    eng_en = 1'b1; eng_hi = '0;
    check("tmo_next_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_data = 32'h12345678;
    tick();
    cmd_valid = 1'b0;
    wait_rsp(10, n);
    check("after_tmo_latency", n, 2);
    check("after_tmo_data", rsp_data, 32'h0C951F11);
    check("after_tmo_err", rsp_err, 0);
    tick();

    // backpressure: three commands, buffer of two
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_data = 32'h11111111;
    tick();
    tick();
    tick();
    check("bp_a_valid", rsp_valid, 1);
    check("bp_b_ready", cmd_ready, 1);
    cmd_data = 32'h22222222;
    tick();
    cmd_data = 32'h33333333;
    tick();
    tick();
    check("bp_full_ready0", cmd_ready, 0);
    tick();
    check("bp_full_ready1", cmd_ready, 0);
    check("bp_head_a", rsp_data, 32'h0FB05878);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp_c_ready", cmd_ready, 1);
    check("bp_head_b", rsp_data, 32'h3C836B4B);
    tick();
    cmd_valid = 1'b0;
    check("bp_c_issued", eng_in_data, 32'h33333333);
    rsp_ready = 1'b1;
    tick();
    tick();
    check("bp_head_c", rsp_data, 32'h2D927A5A);
    check("bp_c_valid", rsp_valid, 1);
    tick();
    check("bp_drained", rsp_valid, 0);

    // response on the timeout cycle wins
    eng_delay = 14;
    cmd_valid = 1'b1; cmd_data = 32'hCAFEF00D;
    tick();
    cmd_valid = 1'b0;
    wait_rsp(40, n);
    check("race_latency", n, 16);
    check("race_err", rsp_err, 0);
    check("race_data", rsp_data, 32'hD45FB964);
    tick();

    // one cycle too late: timeout, then the stray response is ignored
    eng_delay = 15;
    cmd_valid = 1'b1; cmd_data = 32'hCAFEF00D;
    tick();
    cmd_valid = 1'b0;
    wait_rsp(40, n);
    check("late_latency", n, 16);
    check("late_err", rsp_err, 1);
    tick();
    tick();
    check("late_no_push", rsp_valid, 0);
    eng_delay = 0;

    // reset in WAIT abandons the request
    eng_en = 1'b0;
    cmd_valid = 1'b1; cmd_data = 32'h00000055;
    tick();
    cmd_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rwait_cmd_ready", cmd_ready, 1);
    check("rwait_rsp_valid", rsp_valid, 0);
    check("rwait_word", eng_in_data, 32'h0);
    force_rdy = 1'b1;
    tick();
    force_rdy = 1'b0;
    tick();
    check("rwait_late_ignored", rsp_valid, 0);
    eng_en = 1'b1;

`ifdef BAD_HASH_CLIENT_CHECK_EN
    eng_bad = 1'b1;
    cmd_valid = 1'b1; cmd_data = 32'h1;
    tick();
    cmd_valid = 1'b0;
    wait_rsp(10, n);
    check("chk_err", rsp_err, 1);
    check("chk_data", rsp_data, 32'hDEADBEEF);
    tick();
    check("chk_count1", err_count, 8'd1);
    for (int i = 0; i < 260; i++) begin
      cmd_valid = 1'b1; cmd_data = 32'h1;
      tick();
      cmd_valid = 1'b0;
      wait_rsp(10, n);
      tick();
    end
    check("chk_saturate", err_count, 8'd255);
    eng_bad = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
